// File: rtl/fetch_flow_ctrl.sv
// Credit/flow controller between IFetch and the predecode buffer: gates fetch issue on
// buffer credits and fetch-ID availability, and sequences mispredict flush -> restart.
module fetch_flow_ctrl #(
    parameter int          BUF_SIZE  = 4,
    parameter int          FETCH_LAT = 2,
    parameter int          NUM_FID   = 8,
    parameter logic [30:0] RESET_PC  = 31'h0,
    localparam int         FID_W     = $clog2(NUM_FID),
    localparam int         OCC_W     = $clog2(BUF_SIZE) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_mispred,
    input  logic [FID_W-1:0] IN_mispredFID,
    input  logic [30:0]      IN_redirPC,
    input  logic             IN_ifReady,
    input  logic             IN_ifArrive,
    input  logic [OCC_W-1:0] IN_pdFreed,
    input  logic             IN_fidCommit,
    output logic             OUT_fetchEn,
    output logic [FID_W-1:0] OUT_fetchID,
    output logic             OUT_redirect,
    output logic [30:0]      OUT_redirPC,
    output logic             OUT_pdFlush,
    output logic             OUT_pdFull
);

    localparam int INF_W = $clog2(FETCH_LAT + 1);
    localparam int SUM_W = ((OCC_W > INF_W) ? OCC_W : INF_W) + 1;
    localparam logic [FID_W:0] FID_FULL = (FID_W + 1)'(NUM_FID);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        RESTART
    } state_t;

    state_t             state;
    logic [OCC_W-1:0]   occ;
    logic [INF_W-1:0]   inflight;
    logic [INF_W-1:0]   flush_cnt;
    logic [FID_W:0]     fid_head;
    logic [FID_W:0]     fid_tail;
    logic [30:0]        redir_pc;
    logic               pd_full;

    logic [FID_W:0]     fid_used;
    logic [SUM_W-1:0]   credit_used;
    logic [SUM_W-1:0]   occ_calc;
    logic [SUM_W-1:0]   inflight_calc;
    logic [FID_W-1:0]   tail_dist;
    logic [FID_W:0]     mispred_tail;
    logic               fetch_en;
    logic               issue;

    always_comb begin
        fid_used      = fid_tail - fid_head;
        credit_used   = SUM_W'(occ) + SUM_W'(inflight);
        fetch_en      = (state == RUN) && (credit_used < SUM_W'(BUF_SIZE))
                        && (fid_used < FID_FULL) && !IN_mispred;
        issue         = fetch_en && IN_ifReady;
        occ_calc      = SUM_W'(occ) + SUM_W'(IN_ifArrive) - SUM_W'(IN_pdFreed);
        inflight_calc = SUM_W'(inflight) + SUM_W'(issue) - SUM_W'(IN_ifArrive);
        // The mispredicted ID is outstanding, so ID+1 lies in (head, head+NUM_FID];
        // a zero low-bit distance therefore means a full window, which fixes the wrap bit.
        tail_dist     = (IN_mispredFID + FID_W'(1)) - fid_head[FID_W-1:0];
        mispred_tail  = fid_head + ((tail_dist == '0) ? FID_FULL : {1'b0, tail_dist});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESTART;
            redir_pc  <= RESET_PC;
            occ       <= '0;
            inflight  <= '0;
            fid_head  <= '0;
            fid_tail  <= '0;
            flush_cnt <= '0;
            pd_full   <= 1'b0;
        end else begin
            if (IN_fidCommit)
                fid_head <= fid_head + (FID_W + 1)'(1);

            if (IN_mispred) begin
                state     <= FLUSH;
                flush_cnt <= INF_W'(FETCH_LAT);
                redir_pc  <= IN_redirPC;
                fid_tail  <= mispred_tail;
                occ       <= '0;
                inflight  <= '0;
                pd_full   <= 1'b0;
            end else begin
                case (state)
                    RUN, RESTART: begin
                        state    <= RUN;
                        occ      <= occ_calc[OCC_W-1:0];
                        inflight <= inflight_calc[INF_W-1:0];
                        pd_full  <= (occ_calc == SUM_W'(BUF_SIZE));
                        if (issue)
                            fid_tail <= fid_tail + (FID_W + 1)'(1);
                    end
                    FLUSH: begin
                        // Arrivals and frees during the flush belong to discarded packets.
                        flush_cnt <= flush_cnt - INF_W'(1);
                        if (flush_cnt == INF_W'(1))
                            state <= RESTART;
                    end
                    default: state <= RESTART;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(IN_fidCommit && (fid_head == fid_tail)));
            if (state != FLUSH && !IN_mispred) begin
                assert (occ_calc <= SUM_W'(BUF_SIZE));
                assert (inflight_calc <= SUM_W'(FETCH_LAT));
            end
        end
    end

    assign OUT_fetchEn  = fetch_en;
    assign OUT_fetchID  = fid_tail[FID_W-1:0];
    assign OUT_redirect = (state == RESTART) && !rst;
    assign OUT_redirPC  = redir_pc;
    assign OUT_pdFlush  = (state == FLUSH);
    assign OUT_pdFull   = pd_full;

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Directed bench for fetch_flow_ctrl: expected fetch IDs and redirect PCs are queued by the
// stimulus and popped by a monitor whenever the DUT issues or redirects.
module tb_fetch_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IN_mispred = 1'b0;
    logic [2:0]  IN_mispredFID = '0;
    logic [30:0] IN_redirPC = '0;
    logic        IN_ifReady = 1'b0;
    logic        IN_ifArrive = 1'b0;
    logic [2:0]  IN_pdFreed = '0;
    logic        IN_fidCommit = 1'b0;
    logic        OUT_fetchEn;
    logic [2:0]  OUT_fetchID;
    logic        OUT_redirect;
    logic [30:0] OUT_redirPC;
    logic        OUT_pdFlush;
    logic        OUT_pdFull;

    int total = 0;
    int bad   = 0;
    logic [2:0]  exp_id[$];
    logic [30:0] exp_pc[$];

    fetch_flow_ctrl #(
        .BUF_SIZE (4),
        .FETCH_LAT(2),
        .NUM_FID  (8),
        .RESET_PC (31'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_mispred   (IN_mispred),
        .IN_mispredFID(IN_mispredFID),
        .IN_redirPC   (IN_redirPC),
        .IN_ifReady   (IN_ifReady),
        .IN_ifArrive  (IN_ifArrive),
        .IN_pdFreed   (IN_pdFreed),
        .IN_fidCommit (IN_fidCommit),
        .OUT_fetchEn  (OUT_fetchEn),
        .OUT_fetchID  (OUT_fetchID),
        .OUT_redirect (OUT_redirect),
        .OUT_redirPC  (OUT_redirPC),
        .OUT_pdFlush  (OUT_pdFlush),
        .OUT_pdFull   (OUT_pdFull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Args: mispred, mispredFID, redirPC, ifReady, ifArrive, pdFreed, fidCommit.
    task automatic drive(input int mp, input int mfid, input int mpc, input int rdy,
                         input int arr, input int fr, input int cm);
        IN_mispred    = mp[0];
        IN_mispredFID = mfid[2:0];
        IN_redirPC    = mpc[30:0];
        IN_ifReady    = rdy[0];
        IN_ifArrive   = arr[0];
        IN_pdFreed    = fr[2:0];
        IN_fidCommit  = cm[0];
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [2:0]  eid;
        logic [30:0] epc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (OUT_fetchEn && IN_ifReady) begin
                    total++;
                    if (exp_id.size() == 0) begin
                        bad++;
                        $display("FAIL issue_id: unexpected issue with id %0d", OUT_fetchID);
                    end else begin
                        eid = exp_id.pop_front();
                        if (OUT_fetchID !== eid) begin
                            bad++;
                            $display("FAIL issue_id: got %0d expected %0d", OUT_fetchID, eid);
                        end
                    end
                end
                if (OUT_redirect) begin
                    total++;
                    if (exp_pc.size() == 0) begin
                        bad++;
                        $display("FAIL redirect_pc: unexpected redirect to %0h", OUT_redirPC);
                    end else begin
                        epc = exp_pc.pop_front();
                        if (OUT_redirPC !== epc) begin
                            bad++;
                            $display("FAIL redirect_pc: got %0h expected %0h", OUT_redirPC, epc);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        repeat (3) tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_fetch_en", 32'(OUT_fetchEn), 32'd0);
        chk("rst_redirect", 32'(OUT_redirect), 32'd0);
        chk("rst_pd_flush", 32'(OUT_pdFlush), 32'd0);
        chk("rst_pd_full", 32'(OUT_pdFull), 32'd0);
        chk("rst_fetch_id", 32'(OUT_fetchID), 32'd0);

        // Restart pulse right after reset, then issue IDs 0..3 until credits run out.
        exp_pc.push_back(31'h0);
        rst = 1'b0;
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("restart_no_fetch", 32'(OUT_fetchEn), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) exp_id.push_back(3'(i));
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 0, 0);
        chk("credit_stall_a", 32'(OUT_fetchEn), 32'd0);
        tick();
        drive(0, 0, 0, 1, 1, 0, 0);
        chk("credit_stall_b", 32'(OUT_fetchEn), 32'd0);
        tick();
        drive(0, 0, 0, 1, 0, 1, 0);
        chk("pd_full_set", 32'(OUT_pdFull), 32'd1);
        chk("full_no_fetch", 32'(OUT_fetchEn), 32'd0);
        tick();
        exp_id.push_back(3'd4);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("free_reenables", 32'(OUT_fetchEn), 32'd1);
        chk("id_after_free", 32'(OUT_fetchID), 32'd4);
        tick();
        drive(0, 0, 0, 1, 0, 2, 0);
        chk("credit_stall_c", 32'(OUT_fetchEn), 32'd0);
        tick();
        exp_id.push_back(3'd5);
        drive(0, 0, 0, 1, 1, 0, 0); tick();

        // Mispredict on FID 2 while credits are available.
        drive(1, 2, 'h100, 1, 0, 0, 0);
        chk("mispred_blocks_issue", 32'(OUT_fetchEn), 32'd0);
        tick();
        drive(0, 0, 0, 1, 1, 1, 0);
        chk("flush1_a", 32'(OUT_pdFlush), 32'd1);
        chk("flush_no_fetch", 32'(OUT_fetchEn), 32'd0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("flush1_b", 32'(OUT_pdFlush), 32'd1);
        tick();
        exp_pc.push_back(31'h100);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("flush1_done", 32'(OUT_pdFlush), 32'd0);
        chk("redirect1", 32'(OUT_redirect), 32'd1);
        tick();
        exp_id.push_back(3'd3);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("occ_cleared", 32'(OUT_pdFull), 32'd0);
        chk("id_after_flush", 32'(OUT_fetchID), 32'd3);
        tick();

        // Second mispredict during FLUSH extends it; only the later PC is redirected to.
        drive(1, 3, 'h180, 1, 0, 0, 0);
        chk("mispred2_blocks", 32'(OUT_fetchEn), 32'd0);
        tick();
        drive(1, 3, 'h200, 1, 1, 0, 0);
        chk("flush2_a", 32'(OUT_pdFlush), 32'd1);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("flush2_b", 32'(OUT_pdFlush), 32'd1);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("flush2_extended", 32'(OUT_pdFlush), 32'd1);
        chk("no_early_redirect", 32'(OUT_redirect), 32'd0);
        tick();
        exp_pc.push_back(31'h200);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("redirect2", 32'(OUT_redirect), 32'd1);
        tick();

        // Exhaust the eight fetch IDs with no commits; arrive+free keep the buffer empty.
        for (int i = 4; i < 8; i++) exp_id.push_back(3'(i));
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 1, 0); tick();
        drive(0, 0, 0, 1, 1, 1, 0); tick();
        drive(0, 0, 0, 1, 1, 1, 0);
        chk("fid_limit_a", 32'(OUT_fetchEn), 32'd0);
        tick();
        drive(0, 0, 0, 1, 1, 1, 0);
        chk("fid_limit_b", 32'(OUT_fetchEn), 32'd0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("fid_limit_commit_cycle", 32'(OUT_fetchEn), 32'd0);
        tick();
        exp_id.push_back(3'd0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("commit_reenables", 32'(OUT_fetchEn), 32'd1);
        chk("id_wraps", 32'(OUT_fetchID), 32'd0);
        tick();

        // Reset in the middle of a flush abandons it and restarts at RESET_PC.
        drive(1, 7, 'h300, 0, 0, 0, 0); tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("flush3", 32'(OUT_pdFlush), 32'd1);
        tick();
        rst = 1'b0;
        exp_pc.push_back(31'h0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("rst_flush_restart", 32'(OUT_redirect), 32'd1);
        chk("rst_flush_cleared", 32'(OUT_pdFlush), 32'd0);
        chk("rst_flush_id", 32'(OUT_fetchID), 32'd0);
        tick();
        exp_id.push_back(3'd0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("run_after_rst", 32'(OUT_fetchEn), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();

        chk("id_queue_drained", 32'(exp_id.size()), 32'd0);
        chk("pc_queue_drained", 32'(exp_pc.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
